alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Iterative multiply/divide unit that runs beside the combinational ALU in the MIPS datapath.
//  Implements MULT/MULTU/DIV/DIVU with operand width set by parameter.
//  Results go to architectural HI/LO registers held inside this block.
//  The pipeline stalls on busy. MTHI/MTLO write HI/LO directly.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; must be >= 2
// PORTS
//  clk      in   1      clock, rising edge
//  reset    in   1      asynchronous, active-high reset
//  start    in   1      launch op; sampled only when state is IDLE or DONE
//  op       in   1      0 = multiply, 1 = divide
//  Sign     in   1      1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU)
//  A        in   WIDTH  multiplicand / dividend, captured on accepted start
//  B        in   WIDTH  multiplier / divisor, captured on accepted start
//  hi_we    in   1      MTHI: load wdata into HI
//  lo_we    in   1      MTLO: load wdata into LO
//  wdata    in   WIDTH  data for MTHI/MTLO
//  busy     out  1      high in CALC and FIX states
//  done     out  1      one-cycle pulse (state DONE); HI/LO already valid this cycle
//  div_zero out  1      high with done when a divide had B == 0
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
//  - Reset state: state = IDLE; busy = 0; done = 0; div_zero = 0; hi = 0; lo = 0.
//  - Reset mid-operation: aborts the op and clears hi/lo immediately.
//  - FSM: IDLE -(start)-> CALC -> FIX -> DONE.
//    - DONE -(start)-> CALC; DONE -(else)-> IDLE.
//    - CALC lasts exactly WIDTH cycles, with a counter from WIDTH-1 down to 0.
//    - FIX lasts 1 cycle.
//  - Latency: start sampled at edge t.
//    - busy is high from t+1 through t+WIDTH+1.
//    - done is high in cycle t+WIDTH+2.
//    - Timing is data-independent, including B == 0.
//  - Operand capture:
//    - Operands are latched at start.
//    - If Sign = 1, magnitudes |A| and |B| are used.
//    - |most-negative| is the unsigned value 2^(WIDTH-1).
//    - Flags neg_q = A[W-1]^B[W-1] and neg_r = A[W-1] are recorded.
//    - If Sign = 0, both flags are 0.
//  - Multiply: radix-2 shift-add, one multiplier bit per CALC cycle.
//    - Product is 2*WIDTH bits; FIX negates it if neg_q.
//    - {hi,lo} = product.
//  - Divide: restoring, one quotient bit per CALC cycle.
//    - FIX negates the quotient if neg_q and the remainder if neg_r.
//    - lo = quotient, hi = remainder.
//    - Signed min/-1: lo = min (wraps), hi = 0.
//  - Divide by zero: lo = all ones, hi = A as captured (original sign); div_zero = 1 in the DONE cycle only.
//  - HI/LO are written only on the FIX->DONE edge or by hi_we/lo_we.
//  - hi_we/lo_we:
//    - Honoured only in IDLE or DONE. A write in DONE overrides the fresh result.
//    - Ignored while busy.
//    - If start is accepted in the same cycle, start wins and the write is dropped.
//    - hi_we and lo_we together write both registers.
//  - start while busy is ignored; no queueing.
//  - Only start, hi_we or lo_we in a valid state changes state.
// STRUCTURE
//  - alu_muldiv_pkg:
//    - localparams OP_MUL = 1'b0 and OP_DIV = 1'b1.
//    - State encodings ST_IDLE, ST_CALC, ST_FIX, ST_DONE (2 bits).
//  - One sub-module, muldiv_step: combinational single-iteration datapath.
//    - Multiply mode: add/shift.
//    - Divide mode: trial-subtract/shift.
//    - Parametrised by WIDTH.
//    - Inputs: partial accumulator, shift register, B, mode.
//    - Output: next accumulator and next shift register.
//  - Counter width is $clog2(WIDTH).
// TESTING (WIDTH = 32)
//  1. MULT Sign=1, A=FFFFFFFD (-3), B=00000005 -> done at t+34; hi=FFFFFFFF, lo=FFFFFFF1; busy high t+1..t+33.
//  2. MULTU A=B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//  3. DIV Sign=1, A=FFFFFFF9 (-7), B=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV A=80000000, B=FFFFFFFF -> lo=80000000, hi=0.
//  4. DIVU A=00000007, B=0 -> div_zero=1 in the done cycle only; lo=FFFFFFFF, hi=00000007.
//  5. Handshakes:
//     - start again at t+5 with different operands -> ignored; original result is delivered.
//     - hi_we at t+5 -> ignored.
//     - start in the done cycle -> next done 34 cycles later.
//     - lo_we with start in IDLE -> write dropped.
//  6. Reset at t+10 of a DIV -> busy=0, hi=lo=0 asynchronously; no done; a fresh MULT afterwards yields the correct result.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared opcode and state definitions for the iterative multiply/divide unit.
package alu_muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// trial-subtract for divide, operating on unsigned magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] sr_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] sr_o
);
    import alu_muldiv_pkg::*;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum = {1'b0, acc_i} + (sr_i[0] ? {1'b0, b_i} : '0);
        // The shifted-out acc MSB makes the partial remainder exceed any divisor,
        // and the true difference then still fits in WIDTH bits.
        rem  = {acc_i[WIDTH-2:0], sr_i[WIDTH-1]};
        diff = rem - b_i;
        ge   = acc_i[WIDTH-1] | (rem >= b_i);
        if (mode_i == OP_MUL) begin
            acc_o = sum[WIDTH:1];
            sr_o  = {sum[0], sr_i[WIDTH-1:1]};
        end else begin
            acc_o = ge ? diff : rem;
            sr_o  = {sr_i[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// fixed WIDTH+2 cycle latency, MTHI/MTLO writes honoured only when not busy.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import alu_muldiv_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             op_q, op_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             divz_q, divz_d;

    logic [WIDTH-1:0]   step_acc, step_sr;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .sr_i   (sr_q),
        .b_i    (m_q),
        .mode_i (op_q),
        .acc_o  (step_acc),
        .sr_o   (step_sr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        m_d     = m_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        divz_d  = divz_q;

        prod = {acc_q, sr_q};
        if (negq_q) prod = -prod;
        quo = negq_q ? -sr_q : sr_q;
        rem = negr_q ? -acc_q : acc_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    // Magnitudes are unsigned, so the most-negative value maps to 2^(WIDTH-1).
                    state_d = ST_CALC;
                    cnt_d   = CNT_LAST;
                    acc_d   = '0;
                    sr_d    = (Sign && A[WIDTH-1]) ? -A : A;
                    m_d     = (Sign && B[WIDTH-1]) ? -B : B;
                    a_d     = A;
                    op_d    = op;
                    negq_d  = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                    negr_d  = Sign & A[WIDTH-1];
                    divz_d  = (op == OP_DIV) && (B == '0);
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                sr_d  = step_sr;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (op_q == OP_MUL) begin
                    {hi_d, lo_d} = prod;
                end else if (divz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            m_q     <= '0;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_MUL;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            m_q     <= m_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
        end
    end

    assign busy     = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done     = (state_q == ST_DONE);
    assign div_zero = done && divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: expected HI/LO come from native SV
// arithmetic, pushed at launch and compared when done pulses.
module tb_alu_muldiv_seq;
    import alu_muldiv_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0, op = 1'b0, Sign = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] A = '0, B = '0, wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_hi = '0, model_lo = '0;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .Sign(Sign),
        .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      x, y, p, q, r;
        logic [63:0] u;
        e.dz = 1'b0;
        if (o == OP_MUL) begin
            if (s) begin
                x = $signed(a); y = $signed(b); p = x * y; u = p;
            end else begin
                u = {32'd0, a} * {32'd0, b};
            end
            e.hi = u[63:32]; e.lo = u[31:0];
        end else if (b == '0) begin
            e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (s) begin
            x = $signed(a); y = $signed(b); q = x / y; r = x % y;
            u = q; e.lo = u[31:0];
            u = r; e.hi = u[31:0];
        end else begin
            e.lo = a / b; e.hi = a % b;
        end
        return e;
    endfunction

    // Every done pulse must match the oldest outstanding launch.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done at %0t: hi=%h lo=%h, no launch outstanding", $time, hi, lo);
            end else begin
                e = sbq.pop_front();
                if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
                    errors++;
                    $display("[TB] FAIL result at %0t: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                             $time, hi, lo, div_zero, e.hi, e.lo, e.dz);
                end
                model_hi = e.hi;
                model_lo = e.lo;
            end
        end else if (div_zero === 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL div_zero_outside_done at %0t: div_zero=1, required 0", $time);
        end
    end

    task automatic drive_start(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; Sign = s; A = a; B = b;
        sbq.push_back(model(o, s, a, b));
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic issue(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        drive_start(o, s, a, b);
    endtask

    task automatic check_timing(input string tag);
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            checks++;
            if (n <= W + 1) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_busy cycle %0d: busy=%b done=%b, required busy=1 done=0", tag, n, busy, done);
                end
            end else if (busy !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_done cycle %0d: busy=%b done=%b, required busy=0 done=1", tag, n, busy, done);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] d);
        @(negedge clk);
        hi_we = hw; lo_we = lw; wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        checks++;
        if (hi !== model_hi || lo !== model_lo) begin
            errors++;
            $display("[TB] FAIL %s: hi=%h lo=%h, required hi=%h lo=%h", tag, hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_reset();
        idle_cycles(2);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero",
                     busy, done, div_zero, hi, lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        issue(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
        check_timing("mult_neg");
        issue(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_timing("multu_max");
        issue(OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000);
        check_timing("mult_min_min");
        for (int i = 0; i < 3; i++) begin
            issue(OP_MUL, 1'($urandom_range(0, 1)), $urandom, $urandom);
            check_timing("mul_rand");
        end
    endtask

    task automatic test_div();
        issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        check_timing("div_neg");
        issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_timing("div_min_m1");
        issue(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
        check_timing("divu_big");
        for (int i = 0; i < 3; i++) begin
            issue(OP_DIV, 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 100000)));
            check_timing("div_rand");
        end
    endtask

    task automatic test_div_zero();
        issue(OP_DIV, 1'b0, 32'h0000_0007, 32'h0000_0000);
        check_timing("divu_zero");
        @(negedge clk);
        checks++;
        if (div_zero !== 1'b0 || hi !== 32'h0000_0007 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL div_zero_after_done: dz=%b hi=%h lo=%h, required dz=0 hi=00000007 lo=ffffffff",
                     div_zero, hi, lo);
        end
        issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000);
        check_timing("div_zero_signed");
    endtask

    task automatic test_busy_handshake();
        issue(OP_MUL, 1'b0, 32'h0001_2345, 32'h0001_0000);
        for (int n = 1; n <= W + 2; n++) begin
            @(negedge clk);
            checks++;
            if ((n <= W + 1) ? (busy !== 1'b1 || done !== 1'b0) : (busy !== 1'b0 || done !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL busy_handshake cycle %0d: busy=%b done=%b", n, busy, done);
            end
            if (n == 4) begin
                start = 1'b1; op = OP_DIV; Sign = 1'b0; A = 32'd99; B = 32'd3;
                hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (n == 5) begin
                start = 1'b0; hi_we = 1'b0;
            end
        end
        idle_cycles(40);
        check_regs("busy_writes_ignored");
    endtask

    task automatic test_back_to_back();
        issue(OP_MUL, 1'b1, 32'h0000_0100, 32'hFFFF_FF00);
        check_timing("b2b_first");
        hi_we = 1'b1; wdata = 32'h5555_AAAA;
        drive_start(OP_DIV, 1'b0, 32'd1000, 32'd7);
        checks++;
        if (hi !== model_hi || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_write_dropped: hi=%h busy=%b, required hi=%h busy=1", hi, busy, model_hi);
        end
        check_timing("b2b_second");
    endtask

    task automatic test_lo_we_start();
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        drive_start(OP_MUL, 1'b0, 32'd6, 32'd7);
        checks++;
        if (lo !== model_lo) begin
            errors++;
            $display("[TB] FAIL lo_we_with_start: lo=%h, required %h", lo, model_lo);
        end
        check_timing("lo_we_start");
    endtask

    task automatic test_mthi_mtlo();
        mt_write(1'b1, 1'b0, 32'hA5A5_0001);
        check_regs("mthi_only");
        mt_write(1'b0, 1'b1, 32'h5A5A_0002);
        check_regs("mtlo_only");
        mt_write(1'b1, 1'b1, 32'h1357_9BDF);
        check_regs("mthi_mtlo_both");
        issue(OP_MUL, 1'b0, 32'd5, 32'd9);
        check_timing("done_override");
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        model_hi = 32'h0BAD_F00D;
        check_regs("write_in_done");
    endtask

    task automatic test_reset_midop();
        issue(OP_DIV, 1'b0, 32'h7654_3210, 32'h0000_0013);
        idle_cycles(9);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        sbq.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(40);
        check_regs("after_reset");
        issue(OP_MUL, 1'b1, 32'hFFFF_FFF0, 32'h0000_0011);
        check_timing("mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_busy_handshake();
        test_back_to_back();
        test_lo_we_start();
        test_mthi_mtlo();
        test_reset_midop();
        idle_cycles(3);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL outstanding_results: %0d left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
